io_test_mux_gen: RTL and testbench

Parametrised successor of the scope test-signal multiplexer. It selects CChCnt output channels, each CGrpW bits wide, from CGrpCnt input groups of the same width.
- Selections are written through the IO bus into per-channel shadow registers, then committed atomically to all channels so the scope never samples a mixed mapping.
- Selections and status read back on AIoMiso so the PC can label plots.
- Sits on the peripheral IO bus; its output feeds the scope sampler.

---
 rtl/io_test_mux_gen_pkg.sv | 34 +++
 rtl/io_test_mux_gen_chan.sv | 60 ++++++
 rtl/io_test_mux_gen.sv | 142 ++++++++++++++
 tb/tb_io_test_mux_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_test_mux_gen_pkg.sv
// Shared constants for the scope test-signal multiplexer: register offsets,
// CTRL/STAT bit positions and IO bus size/operation encodings.
package io_test_mux_gen_pkg;

  localparam logic [1:0] CRegCtrl   = 2'd0;
  localparam logic [1:0] CRegSel    = 2'd1;
  localparam logic [1:0] CRegCommit = 2'd2;
  localparam int         CRegCnt    = 3;

  localparam int CCtrlPtrRst = 0;
  localparam int CCtrlAuto   = 1;
  localparam int CCtrlErrClr = 2;

  localparam int CStatAuto = 6;
  localparam int CStatErr  = 7;

  // Size strobes are one-hot; an all-zero strobe means no access.
  localparam logic [3:0] CSizeNone  = 4'b0000;
  localparam logic [3:0] CSizeByte  = 4'b0001;
  localparam logic [3:0] CSizeWord  = 4'b0010;
  localparam logic [3:0] CSizeDword = 4'b0100;
  localparam logic [3:0] CSizeQword = 4'b1000;

  typedef enum logic [1:0] {
    OpNone,
    OpRead,
    OpWrite
  } io_op_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_test_mux_gen_chan.sv
// One output channel: shadow/active select registers, the group mux and the
// registered channel output.
module test_mux_chan
  import io_test_mux_gen_pkg::*;
#(
  parameter int               CGrpCnt   = 64,
  parameter int               CGrpW     = 8,
  parameter int               CIdxW     = 6,
  parameter logic [CIdxW-1:0] CResetIdx = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       shadow_we_i,
  input  logic                       commit_i,
  input  logic                       auto_we_i,
  input  logic [CIdxW-1:0]           idx_i,
  input  logic [CGrpCnt*CGrpW-1:0]   test_i,
  output logic [CIdxW-1:0]           shadow_o,
  output logic [CIdxW-1:0]           active_o,
  output logic [CGrpW-1:0]           out_o
);

  logic [CIdxW-1:0] shadow_q, shadow_d;
  logic [CIdxW-1:0] active_q, active_d;
  logic [CGrpW-1:0] out_q, out_d;

  // Commit copies the pre-edge shadow so all channels switch on the same edge.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    out_d    = '0;
    if (shadow_we_i) shadow_d = idx_i;
    if (commit_i) begin
      active_d = shadow_q;
    end else if (auto_we_i) begin
      active_d = idx_i;
    end
    for (int g = 0; g < CGrpCnt; g++) begin
      if (active_q == CIdxW'(g)) out_d = test_i[g*CGrpW +: CGrpW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= CResetIdx;
      active_q <= CResetIdx;
      out_q    <= '0;
    end else if (en_i) begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;
  assign out_o    = out_q;

endmodule

// File: rtl/io_test_mux_gen.sv
// Scope test-signal multiplexer: IO register decode, select pointer, error and
// auto-commit flags, readback and the mapping-change pulse around N channels.
module io_test_mux_gen
  import io_test_mux_gen_pkg::*;
#(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int          CChCnt    = 16,
  parameter int          CGrpCnt   = 64,
  parameter int          CGrpW     = 8,
  parameter int          CIdxW     = 6
) (
  input  logic                       AClkH,
  input  logic                       AResetHN,
  input  logic                       AClkHEn,
  input  logic [15:0]                AIoAddr,
  output logic [63:0]                AIoMiso,
  input  logic [63:0]                AIoMosi,
  input  logic [3:0]                 AIoWrSize,
  input  logic [3:0]                 AIoRdSize,
  output logic                       AIoAddrAck,
  output logic                       AIoAddrErr,
  input  logic [CGrpCnt*CGrpW-1:0]   ATestIn,
  output logic [CChCnt*CGrpW-1:0]    ATestOut,
  output logic                       AMuxChg
);

  localparam int CPtrW = ptr_width(CChCnt);

  logic [15:0]      regOffs;
  logic [1:0]       regSel;
  logic             inRange, wrAny, rdAny, sizeOk;
  io_op_e           ioOp;
  logic             ctrlWr, selWr, selRd, commitWr;
  logic [7:0]       wrByte;
  logic             idxLegal, shadowWrOk;
  logic [CIdxW-1:0] idxNew;
  logic [15:0]      rdWord;
  logic             unused_mosi;

  logic [CPtrW-1:0] ptr_q, ptr_d, ptrNext;
  logic             auto_q, auto_d;
  logic             err_q, err_d;
  logic             muxChg_q, muxChg_d;

  logic [CIdxW-1:0] shadowIdx [CChCnt];
  logic [CIdxW-1:0] activeIdx [CChCnt];

  assign regOffs = AIoAddr - CAddrBase;
  assign regSel  = regOffs[1:0];
  assign inRange = regOffs < 16'(CRegCnt);
  assign wrAny   = AIoWrSize != CSizeNone;
  assign rdAny   = AIoRdSize != CSizeNone;
  assign sizeOk  = (AIoWrSize == CSizeNone || AIoWrSize == CSizeByte) &&
                   (AIoRdSize == CSizeNone || AIoRdSize == CSizeByte);

  assign AIoAddrAck = inRange && (wrAny || rdAny) && sizeOk;
  assign AIoAddrErr = inRange && (wrAny || rdAny) && !sizeOk;

  // A combined read+write is treated as a write so the pointer moves once.
  always_comb begin
    ioOp = OpNone;
    if (AIoAddrAck) ioOp = wrAny ? OpWrite : OpRead;
  end

  assign ctrlWr   = (ioOp == OpWrite) && (regSel == CRegCtrl);
  assign selWr    = (ioOp == OpWrite) && (regSel == CRegSel);
  assign commitWr = (ioOp == OpWrite) && (regSel == CRegCommit);
  assign selRd    = (ioOp == OpRead)  && (regSel == CRegSel);

  assign wrByte      = AIoMosi[7:0];
  assign unused_mosi = ^AIoMosi[63:8];
  assign idxLegal    = (int'(wrByte) < CGrpCnt) && ((wrByte >> CIdxW) == 8'd0);
  assign idxNew      = wrByte[CIdxW-1:0];
  assign shadowWrOk  = selWr && idxLegal;

  assign ptrNext = (ptr_q == CPtrW'(CChCnt - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    ptr_d    = ptr_q;
    auto_d   = auto_q;
    err_d    = err_q;
    muxChg_d = 1'b0;
    if (ctrlWr) begin
      if (wrByte[CCtrlPtrRst]) ptr_d = '0;
      auto_d = wrByte[CCtrlAuto];
      if (wrByte[CCtrlErrClr]) err_d = 1'b0;
    end
    if (selWr || selRd) ptr_d = ptrNext;
    if (selWr && !idxLegal) err_d = 1'b1;
    muxChg_d = commitWr || (shadowWrOk && auto_q);
  end

  // The change pulse is a plain register, so it holds while the enable is low.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      ptr_q    <= '0;
      auto_q   <= 1'b0;
      err_q    <= 1'b0;
      muxChg_q <= 1'b0;
    end else if (AClkHEn) begin
      ptr_q    <= ptr_d;
      auto_q   <= auto_d;
      err_q    <= err_d;
      muxChg_q <= muxChg_d;
    end
  end

  for (genvar c = 0; c < CChCnt; c++) begin : g_chan
    test_mux_chan #(
      .CGrpCnt  (CGrpCnt),
      .CGrpW    (CGrpW),
      .CIdxW    (CIdxW),
      .CResetIdx(CIdxW'(c % CGrpCnt))
    ) u_chan (
      .clk_i      (AClkH),
      .rst_ni     (AResetHN),
      .en_i       (AClkHEn),
      .shadow_we_i(shadowWrOk && (ptr_q == CPtrW'(c))),
      .commit_i   (commitWr),
      .auto_we_i  (shadowWrOk && auto_q && (ptr_q == CPtrW'(c))),
      .idx_i      (idxNew),
      .test_i     (ATestIn),
      .shadow_o   (shadowIdx[c]),
      .active_o   (activeIdx[c]),
      .out_o      (ATestOut[c*CGrpW +: CGrpW])
    );
  end

  always_comb begin
    rdWord = 16'h0000;
    case (regSel)
      CRegCtrl:   rdWord = {8'(ptr_q), err_q, auto_q, 6'b000000};
      CRegSel:    rdWord = {8'h00, 8'(shadowIdx[ptr_q])};
      CRegCommit: rdWord = {8'h00, 8'(activeIdx[ptr_q])};
      default:    rdWord = 16'h0000;
    endcase
  end

  assign AIoMiso = AIoAddrAck ? {48'h0, rdWord} : 64'h0;
  assign AMuxChg = muxChg_q;

endmodule

// File: tb/tb_io_test_mux_gen.sv
// Scoreboard bench for io_test_mux_gen: stimulus queues expected IO and
// channel-output responses, a monitor pops and compares them mid-cycle.
module tb_io_test_mux_gen;
  import io_test_mux_gen_pkg::*;

  localparam int          CChCnt  = 16;
  localparam int          CGrpCnt = 64;
  localparam int          CGrpW   = 8;
  localparam int          CIdxW   = 6;
  localparam int          COutW   = CChCnt * CGrpW;
  localparam logic [15:0] CBase   = 16'h0120;

  logic                      clk = 1'b0;
  logic                      AResetHN;
  logic                      AClkHEn;
  logic [15:0]               AIoAddr;
  logic [63:0]               AIoMiso;
  logic [63:0]               AIoMosi;
  logic [3:0]                AIoWrSize;
  logic [3:0]                AIoRdSize;
  logic                      AIoAddrAck;
  logic                      AIoAddrErr;
  logic [CGrpCnt*CGrpW-1:0]  ATestIn;
  logic [COutW-1:0]          ATestOut;
  logic                      AMuxChg;

  io_test_mux_gen #(
    .CAddrBase(CBase),
    .CChCnt   (CChCnt),
    .CGrpCnt  (CGrpCnt),
    .CGrpW    (CGrpW),
    .CIdxW    (CIdxW)
  ) dut (
    .AClkH     (clk),
    .AResetHN  (AResetHN),
    .AClkHEn   (AClkHEn),
    .AIoAddr   (AIoAddr),
    .AIoMiso   (AIoMiso),
    .AIoMosi   (AIoMosi),
    .AIoWrSize (AIoWrSize),
    .AIoRdSize (AIoRdSize),
    .AIoAddrAck(AIoAddrAck),
    .AIoAddrErr(AIoAddrErr),
    .ATestIn   (ATestIn),
    .ATestOut  (ATestOut),
    .AMuxChg   (AMuxChg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          expAck;
    bit          expErr;
    bit          chkData;
    logic [63:0] expData;
  } io_exp_t;

  typedef struct {
    string            name;
    logic [COutW-1:0] expOut;
    bit               expChg;
  } out_exp_t;

  io_exp_t  ioQ[$];
  out_exp_t outQ[$];
  int       nTests = 0;
  int       nFail  = 0;
  int       expMap [CChCnt];
  logic     outStrobe = 1'b0;

  function automatic logic [CGrpW-1:0] grpVal(input int g);
    return CGrpW'(g * 3 + 1);
  endfunction

  task automatic compare(input string name, input logic [COutW-1:0] act,
                         input logic [COutW-1:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one IO access for exactly one clock and queues its expected response.
  task automatic applyStimulus(input logic [15:0] addr, input logic [3:0] wrSize,
                               input logic [3:0] rdSize, input logic [7:0] data,
                               input bit expAck, input bit expErr, input bit chkData,
                               input logic [15:0] expData, input string name);
    io_exp_t e;
    e.name    = name;
    e.expAck  = expAck;
    e.expErr  = expErr;
    e.chkData = chkData;
    e.expData = {48'h0, expData};
    ioQ.push_back(e);
    AIoAddr   = addr;
    AIoWrSize = wrSize;
    AIoRdSize = rdSize;
    AIoMosi   = {56'hA5A5_A5A5_A5A5_A5, data};
    @(posedge clk);
    #1;
    AIoWrSize = CSizeNone;
    AIoRdSize = CSizeNone;
    AIoMosi   = 64'h0;
  endtask

  task automatic wrReg(input int off, input logic [7:0] data, input string name);
    applyStimulus(CBase + 16'(off), CSizeByte, CSizeNone, data, 1'b1, 1'b0, 1'b0, 16'h0, name);
  endtask

  task automatic rdReg(input int off, input logic [15:0] exp, input string name);
    applyStimulus(CBase + 16'(off), CSizeNone, CSizeByte, 8'h00, 1'b1, 1'b0, 1'b1, exp, name);
  endtask

  // Queues the expected channel outputs for the current cycle, from expMap or zero.
  task automatic checkOutput(input string name, input bit expChg, input bit useZero);
    out_exp_t e;
    e.name   = name;
    e.expChg = expChg;
    e.expOut = '0;
    if (!useZero) begin
      for (int c = 0; c < CChCnt; c++) e.expOut[c*CGrpW +: CGrpW] = grpVal(expMap[c]);
    end
    outQ.push_back(e);
    outStrobe = 1'b1;
    @(posedge clk);
    #1;
    outStrobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    io_exp_t  ie;
    out_exp_t oe;
    forever begin
      @(negedge clk);
      if (AIoWrSize != CSizeNone || AIoRdSize != CSizeNone) begin
        if (ioQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("[TB] FAIL io_unexpected: got access, expected none queued");
        end else begin
          ie = ioQ.pop_front();
          compare({ie.name, "_ack"}, COutW'(AIoAddrAck), COutW'(ie.expAck));
          compare({ie.name, "_err"}, COutW'(AIoAddrErr), COutW'(ie.expErr));
          if (ie.chkData) compare({ie.name, "_data"}, COutW'(AIoMiso), COutW'(ie.expData));
        end
      end
      if (outStrobe) begin
        if (outQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("[TB] FAIL out_unexpected: got strobe, expected none queued");
        end else begin
          oe = outQ.pop_front();
          compare({oe.name, "_out"}, ATestOut, oe.expOut);
          compare({oe.name, "_chg"}, COutW'(AMuxChg), COutW'(oe.expChg));
        end
      end
    end
  end

  initial begin
    AResetHN  = 1'b0;
    AClkHEn   = 1'b1;
    AIoAddr   = 16'h0;
    AIoMosi   = 64'h0;
    AIoWrSize = CSizeNone;
    AIoRdSize = CSizeNone;
    for (int g = 0; g < CGrpCnt; g++) ATestIn[g*CGrpW +: CGrpW] = grpVal(g);
    for (int c = 0; c < CChCnt; c++) expMap[c] = c;

    idle(2);
    checkOutput("rst_hold", 1'b0, 1'b1);
    AResetHN = 1'b1;
    idle(1);
    checkOutput("default_map", 1'b0, 1'b0);
    rdReg(0, 16'h0000, "stat_reset");

    // Reverse mapping through shadow, then atomic commit.
    wrReg(0, 8'h01, "ctrl_ptrrst");
    for (int i = 0; i < 16; i++) wrReg(1, 8'(63 - i), "sel_wr");
    checkOutput("pre_commit", 1'b0, 1'b0);
    rdReg(0, 16'h0000, "stat_wrap");
    wrReg(2, 8'h00, "commit");
    checkOutput("commit_pulse", 1'b1, 1'b0);
    for (int c = 0; c < CChCnt; c++) expMap[c] = 63 - c;
    checkOutput("commit_map", 1'b0, 1'b0);

    // Out-of-range select sets the sticky error but still advances.
    for (int i = 0; i < 3; i++) rdReg(1, 16'(63 - i), "sel_rd_pre");
    wrReg(1, 8'd64, "sel_wr_bad");
    rdReg(0, 16'h0480, "stat_err");
    wrReg(0, 8'h04, "ctrl_errclr");
    rdReg(0, 16'h0400, "stat_errclr");

    // Seventeen reads wrap the pointer; shadow[3] kept its value.
    wrReg(0, 8'h01, "ctrl_ptrrst2");
    for (int i = 0; i < 17; i++) rdReg(1, 16'(63 - (i % 16)), "sel_rd_wrap");
    rdReg(0, 16'h0100, "stat_ptr_wrap");
    rdReg(2, 16'd62, "commit_rd");
    rdReg(0, 16'h0100, "stat_commit_rd");

    // Auto-commit, then three disabled edges including an ignored CTRL write.
    wrReg(0, 8'h03, "ctrl_auto");
    rdReg(0, 16'h0040, "stat_auto");
    wrReg(1, 8'd5, "sel_auto");
    AClkHEn = 1'b0;
    checkOutput("auto_pulse", 1'b1, 1'b0);
    wrReg(0, 8'h01, "ctrl_while_off");
    checkOutput("hold_off", 1'b1, 1'b0);
    AClkHEn = 1'b1;
    checkOutput("hold_resume", 1'b1, 1'b0);
    expMap[0] = 5;
    checkOutput("auto_map", 1'b0, 1'b0);
    rdReg(0, 16'h0140, "stat_after_hold");
    wrReg(0, 8'h03, "ctrl_ptrrst3");
    rdReg(2, 16'd5, "active0_rd");

    // Illegal sizes, out-of-window addresses and a combined read+write.
    wrReg(0, 8'h01, "ctrl_auto_off");
    applyStimulus(CBase + 16'd1, CSizeWord, CSizeNone, 8'h07, 1'b0, 1'b1, 1'b0, 16'h0, "word_wr");
    applyStimulus(CBase + 16'd1, CSizeNone, CSizeWord, 8'h00, 1'b0, 1'b1, 1'b1, 16'h0, "word_rd");
    rdReg(0, 16'h0000, "stat_after_word");
    applyStimulus(CBase + 16'd3, CSizeNone, CSizeByte, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0, "oor_rd");
    applyStimulus(CBase - 16'd1, CSizeByte, CSizeNone, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0, "below_wr");
    rdReg(0, 16'h0000, "stat_after_oor");
    applyStimulus(CBase + 16'd1, CSizeByte, CSizeByte, 8'd20, 1'b1, 1'b0, 1'b1, 16'd5, "sel_rw");
    rdReg(0, 16'h0100, "stat_rw_once");
    wrReg(0, 8'h01, "ctrl_ptrrst4");
    rdReg(1, 16'd20, "rw_write_took");

    // Uncommitted writes are lost across an asynchronous reset.
    wrReg(0, 8'h01, "ctrl_ptrrst5");
    wrReg(1, 8'd10, "sel_uncommit0");
    wrReg(1, 8'd11, "sel_uncommit1");
    checkOutput("uncommitted", 1'b0, 1'b0);
    #2;
    AResetHN = 1'b0;
    checkOutput("async_rst", 1'b0, 1'b1);
    AResetHN = 1'b1;
    for (int c = 0; c < CChCnt; c++) expMap[c] = c;
    idle(1);
    checkOutput("rst_identity", 1'b0, 1'b0);
    rdReg(0, 16'h0000, "stat_rst2");
    wrReg(2, 8'h00, "commit_after_rst");
    checkOutput("commit2_pulse", 1'b1, 1'b0);
    checkOutput("commit2_map", 1'b0, 1'b0);
    rdReg(1, 16'd0, "shadow0_rst");

    for (int i = 0; i < 20 && (ioQ.size() != 0 || outQ.size() != 0); i++) @(negedge clk);
    if (ioQ.size() != 0 || outQ.size() != 0) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", ioQ.size() + outQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
